// File: rtl/mcu_el2_dccm_arb_ctl.sv
// rtl/mcu_el2_dccm_arb_ctl.sv - DCCM port sequencer: post-reset zero fill, then LSU/DMA arbitration.
// Optional DMA anti-starvation counter enabled by defining MCU_DCCM_DMA_STARVE_EN.
module mcu_el2_dccm_arb_ctl #(
  parameter int DCCM_BITS    = 16,
  parameter int FDATA_WIDTH  = 39,
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   lsu_req,
  input  logic                   lsu_wr,
  input  logic [DCCM_BITS-1:0]   lsu_addr_lo,
  input  logic [DCCM_BITS-1:0]   lsu_addr_hi,
  input  logic [FDATA_WIDTH-1:0] lsu_wdata_lo,
  input  logic [FDATA_WIDTH-1:0] lsu_wdata_hi,
  output logic                   lsu_ready,
  output logic                   lsu_rvalid,
  input  logic                   dma_req,
  input  logic                   dma_wr,
  input  logic [DCCM_BITS-1:0]   dma_addr_lo,
  input  logic [DCCM_BITS-1:0]   dma_addr_hi,
  input  logic [FDATA_WIDTH-1:0] dma_wdata_lo,
  input  logic [FDATA_WIDTH-1:0] dma_wdata_hi,
  output logic                   dma_ready,
  output logic                   dma_rvalid,
  input  logic [FDATA_WIDTH-1:0] dccm_rd_data_lo,
  input  logic [FDATA_WIDTH-1:0] dccm_rd_data_hi,
  output logic [FDATA_WIDTH-1:0] rdata_lo,
  output logic [FDATA_WIDTH-1:0] rdata_hi,
  output logic                   dccm_wren,
  output logic                   dccm_rden,
  output logic [DCCM_BITS-1:0]   dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]   dccm_wr_addr_hi,
  output logic [DCCM_BITS-1:0]   dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]   dccm_rd_addr_hi,
  output logic [FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [FDATA_WIDTH-1:0] dccm_wr_data_hi,
  output logic                   init_done
);

  localparam int CNT_W = DCCM_BITS - 2;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] init_cnt;
  logic             init_arm;
  logic             init_done_q;
  logic             lsu_rtag;
  logic             dma_rtag;
  logic             run;
  logic             lsu_gnt;
  logic             dma_gnt;
  logic             dma_force;

  assign run     = (state == ST_RUN);
  assign lsu_gnt = run & lsu_req & ~dma_force;
  assign dma_gnt = run & dma_req & (dma_force | ~lsu_req);

`ifdef MCU_DCCM_DMA_STARVE_EN
  localparam int WAIT_W = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DMA_MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // Once DMA has been held off DMA_MAX_WAIT cycles it takes the port regardless of LSU.
  assign dma_force = run & dma_req & (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wait_cnt <= '0;
    end else if (!run || !dma_req || dma_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  if (DMA_MAX_WAIT >= 0) begin : g_no_starve
    assign dma_force = 1'b0;
  end
`endif

  assign lsu_ready  = lsu_gnt;
  assign dma_ready  = dma_gnt;
  assign lsu_rvalid = lsu_rtag;
  assign dma_rvalid = dma_rtag;
  assign init_done  = init_done_q;

  // Read data is only exposed while a tagged return is in flight, so no stale bank data leaks out.
  assign rdata_lo = (lsu_rtag | dma_rtag) ? dccm_rd_data_lo : '0;
  assign rdata_hi = (lsu_rtag | dma_rtag) ? dccm_rd_data_hi : '0;

  always_comb begin
    dccm_wren       = 1'b0;
    dccm_rden       = 1'b0;
    dccm_wr_addr_lo = '0;
    dccm_wr_addr_hi = '0;
    dccm_rd_addr_lo = '0;
    dccm_rd_addr_hi = '0;
    dccm_wr_data_lo = '0;
    dccm_wr_data_hi = '0;
    if (state == ST_INIT) begin
      // init_arm keeps the bank quiet in the first cycle out of reset.
      if (init_arm) begin
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = {init_cnt, 2'b00};
        dccm_wr_addr_hi = {init_cnt, 2'b00};
      end
    end else if (lsu_gnt) begin
      if (lsu_wr) begin
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = lsu_addr_lo;
        dccm_wr_addr_hi = lsu_addr_hi;
        dccm_wr_data_lo = lsu_wdata_lo;
        dccm_wr_data_hi = lsu_wdata_hi;
      end else begin
        dccm_rden       = 1'b1;
        dccm_rd_addr_lo = lsu_addr_lo;
        dccm_rd_addr_hi = lsu_addr_hi;
      end
    end else if (dma_gnt) begin
      if (dma_wr) begin
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = dma_addr_lo;
        dccm_wr_addr_hi = dma_addr_hi;
        dccm_wr_data_lo = dma_wdata_lo;
        dccm_wr_data_hi = dma_wdata_hi;
      end else begin
        dccm_rden       = 1'b1;
        dccm_rd_addr_lo = dma_addr_lo;
        dccm_rd_addr_hi = dma_addr_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      init_arm    <= 1'b0;
      init_done_q <= 1'b0;
      lsu_rtag    <= 1'b0;
      dma_rtag    <= 1'b0;
    end else begin
      init_arm <= 1'b1;
      lsu_rtag <= lsu_gnt & ~lsu_wr;
      dma_rtag <= dma_gnt & ~dma_wr;
      if ((state == ST_INIT) && init_arm) begin
        init_cnt <= init_cnt + 1'b1;
        if (&init_cnt) begin
          state       <= ST_RUN;
          init_done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mcu_el2_dccm_arb_ctl.sv
// tb/tb_mcu_el2_dccm_arb_ctl.sv - directed-vector bench for mcu_el2_dccm_arb_ctl.
module tb_mcu_el2_dccm_arb_ctl;

  logic        clk;
  logic        rst_l;
  logic        lsu_req, lsu_wr, dma_req, dma_wr;
  logic [15:0] lsu_addr_lo, lsu_addr_hi, dma_addr_lo, dma_addr_hi;
  logic [38:0] lsu_wdata_lo, lsu_wdata_hi, dma_wdata_lo, dma_wdata_hi;
  logic        lsu_ready, lsu_rvalid, dma_ready, dma_rvalid;
  logic [38:0] dccm_rd_data_lo, dccm_rd_data_hi, rdata_lo, rdata_hi;
  logic        dccm_wren, dccm_rden, init_done;
  logic [15:0] dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi;
  logic [38:0] dccm_wr_data_lo, dccm_wr_data_hi;

  int checks = 0;
  int failures = 0;

  mcu_el2_dccm_arb_ctl dut (
    .clk(clk), .rst_l(rst_l),
    .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_addr_lo(lsu_addr_lo), .lsu_addr_hi(lsu_addr_hi),
    .lsu_wdata_lo(lsu_wdata_lo), .lsu_wdata_hi(lsu_wdata_hi),
    .lsu_ready(lsu_ready), .lsu_rvalid(lsu_rvalid),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr_lo(dma_addr_lo), .dma_addr_hi(dma_addr_hi),
    .dma_wdata_lo(dma_wdata_lo), .dma_wdata_hi(dma_wdata_hi),
    .dma_ready(dma_ready), .dma_rvalid(dma_rvalid),
    .dccm_rd_data_lo(dccm_rd_data_lo), .dccm_rd_data_hi(dccm_rd_data_hi),
    .rdata_lo(rdata_lo), .rdata_hi(rdata_hi),
    .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
    .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
    .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
    .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int npulse, addr_err, rdy_err, first_dma, ndma;
  logic lsu_at, lsu_after, found;

  initial begin
    rst_l = 1'b0;
    lsu_req = 0; lsu_wr = 0; dma_req = 0; dma_wr = 0;
    lsu_addr_lo = '0; lsu_addr_hi = '0; dma_addr_lo = '0; dma_addr_hi = '0;
    lsu_wdata_lo = '0; lsu_wdata_hi = '0; dma_wdata_lo = '0; dma_wdata_hi = '0;
    dccm_rd_data_lo = '0; dccm_rd_data_hi = '0;
    #12;
    check("rst_init_done", 64'(init_done), 0);
    check("rst_wren", 64'(dccm_wren), 0);
    check("rst_rden", 64'(dccm_rden), 0);
    check("rst_readies", 64'({lsu_ready, dma_ready}), 0);
    check("rst_rvalids", 64'({lsu_rvalid, dma_rvalid}), 0);

    // Requests held during INIT must never be accepted.
    lsu_req = 1; dma_req = 1;
    @(negedge clk) rst_l = 1'b1;
    npulse = 0; addr_err = 0; rdy_err = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (init_done) break;
      if (dccm_wren) begin
        if (dccm_wr_addr_lo !== 16'(npulse * 4) || dccm_wr_addr_hi !== 16'(npulse * 4) ||
            dccm_wr_data_lo !== '0 || dccm_wr_data_hi !== '0) addr_err++;
        npulse++;
      end
      if (lsu_ready || dma_ready || dccm_rden) rdy_err++;
    end
    lsu_req = 0; dma_req = 0;
    check("init_done", 64'(init_done), 1);
    check("init_pulses", 64'(npulse), 16384);
    check("init_addr_data", 64'(addr_err), 0);
    check("init_no_ready", 64'(rdy_err), 0);

    // LSU read vs DMA write in the same cycle.
    lsu_req = 1; lsu_wr = 0; lsu_addr_lo = 16'h0040; lsu_addr_hi = 16'h0044;
    dma_req = 1; dma_wr = 1; dma_addr_lo = 16'h0080; dma_addr_hi = 16'h0084;
    dma_wdata_lo = 39'h12345; dma_wdata_hi = 39'h6789A;
    #1;
    check("arb_lsu_ready", 64'(lsu_ready), 1);
    check("arb_dma_ready", 64'(dma_ready), 0);
    check("arb_rden", 64'(dccm_rden), 1);
    check("arb_wren", 64'(dccm_wren), 0);
    check("arb_rd_addr_lo", 64'(dccm_rd_addr_lo), 64'h40);
    check("arb_rd_addr_hi", 64'(dccm_rd_addr_hi), 64'h44);
    check("arb_wr_addr_idle", 64'(dccm_wr_addr_lo), 0);
    @(posedge clk); #1;
    lsu_req = 0;
    dccm_rd_data_lo = 39'h5A5A5A5A5A; dccm_rd_data_hi = 39'h0F0F0F0F0F;
    #1;
    check("ret_lsu_rvalid", 64'(lsu_rvalid), 1);
    check("ret_dma_rvalid", 64'(dma_rvalid), 0);
    check("ret_rdata_lo", 64'(rdata_lo), 64'h5A5A5A5A5A);
    check("ret_rdata_hi", 64'(rdata_hi), 64'h0F0F0F0F0F);
    check("dma_wr_ready", 64'(dma_ready), 1);
    check("dma_wr_wren", 64'(dccm_wren), 1);
    check("dma_wr_addr_lo", 64'(dccm_wr_addr_lo), 64'h80);
    check("dma_wr_addr_hi", 64'(dccm_wr_addr_hi), 64'h84);
    check("dma_wr_data_lo", 64'(dccm_wr_data_lo), 64'h12345);
    check("dma_wr_data_hi", 64'(dccm_wr_data_hi), 64'h6789A);
    @(posedge clk); #1;
    dma_req = 0;
    #1;
    check("after_wr_rvalids", 64'({lsu_rvalid, dma_rvalid}), 0);
    check("idle_en", 64'({dccm_wren, dccm_rden}), 0);
    check("idle_rdata_gated", 64'(rdata_lo), 0);

    // Back-to-back reads from alternating requesters.
    lsu_req = 1; lsu_wr = 0; lsu_addr_lo = 16'h0100;
    @(posedge clk); #1;
    lsu_req = 0; dma_req = 1; dma_wr = 0; dma_addr_lo = 16'h0200;
    #1;
    check("alt_lsu_rvalid", 64'(lsu_rvalid), 1);
    check("alt_dma_ready", 64'(dma_ready), 1);
    check("alt_dma_rd_addr", 64'(dccm_rd_addr_lo), 64'h200);
    @(posedge clk); #1;
    dma_req = 0;
    #1;
    check("alt_rvalid_pair", 64'({lsu_rvalid, dma_rvalid}), 64'b01);

    // Misaligned LSU write routes both halves unchanged.
    lsu_req = 1; lsu_wr = 1; lsu_addr_lo = 16'h000C; lsu_addr_hi = 16'h0010;
    lsu_wdata_lo = 39'h7F00000001; lsu_wdata_hi = 39'h0000ABCDEF;
    #1;
    check("mis_wr_addr_lo", 64'(dccm_wr_addr_lo), 64'h0C);
    check("mis_wr_addr_hi", 64'(dccm_wr_addr_hi), 64'h10);
    check("mis_wr_data_lo", 64'(dccm_wr_data_lo), 64'h7F00000001);
    check("mis_wr_data_hi", 64'(dccm_wr_data_hi), 64'h0000ABCDEF);
    check("mis_no_rd", 64'({dccm_rden, dccm_rd_addr_lo}), 0);
    @(posedge clk); #1;
    lsu_req = 0;
    #1;
    check("mis_idle_wren", 64'(dccm_wren), 0);

    // Both requesters held: strict priority, or forced DMA slot every DMA_MAX_WAIT+1 cycles.
    lsu_req = 1; lsu_wr = 1; dma_req = 1; dma_wr = 1;
    first_dma = 0; ndma = 0; lsu_at = 1'b1; lsu_after = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      #1;
      if (first_dma != 0 && c == first_dma + 1) lsu_after = lsu_ready;
      if (dma_ready) begin
        ndma++;
        if (first_dma == 0) begin
          first_dma = c;
          lsu_at = lsu_ready;
        end
      end
      @(posedge clk); #1;
    end
    lsu_req = 0; dma_req = 0;
`ifdef MCU_DCCM_DMA_STARVE_EN
    check("starve_first_grant", 64'(first_dma), 9);
    check("starve_lsu_blocked", 64'(lsu_at), 0);
    check("starve_lsu_resumes", 64'(lsu_after), 1);
    check("starve_grant_count", 64'(ndma), 11);
`else
    check("prio_dma_never", 64'(ndma), 0);
`endif

    // Reset during a pending read return drops it immediately.
    #1;
    lsu_req = 1; lsu_wr = 0; lsu_addr_lo = 16'h0300;
    @(posedge clk); #1;
    lsu_req = 0;
    #1;
    check("pre_rst_rvalid", 64'(lsu_rvalid), 1);
    rst_l = 1'b0;
    #1;
    check("midrd_rst_rvalid", 64'(lsu_rvalid), 0);
    check("midrd_rst_rdata", 64'(rdata_lo), 0);
    check("midrd_rst_init_done", 64'(init_done), 0);
    @(negedge clk) rst_l = 1'b1;

    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dccm_wren) begin found = 1'b1; break; end
    end
    check("reinit_started", 64'(found), 1);
    check("reinit_first_addr", 64'(dccm_wr_addr_lo), 0);

    // Reset once the init counter reaches 100 (address 0x190).
    found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (dccm_wren && dccm_wr_addr_lo == 16'h0190) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("cnt100_reached", 64'(found), 1);
    rst_l = 1'b0;
    #1;
    check("cnt100_rst_wren", 64'(dccm_wren), 0);
    check("cnt100_rst_addr", 64'(dccm_wr_addr_lo), 0);
    check("cnt100_rst_outs", 64'({lsu_ready, dma_ready, lsu_rvalid, dma_rvalid, dccm_rden, init_done}), 0);
    @(negedge clk) rst_l = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dccm_wren) begin found = 1'b1; break; end
    end
    check("restart_seen", 64'(found), 1);
    check("restart_addr0", 64'(dccm_wr_addr_lo), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
